mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, 32, data and byte-address width.
REQ-002 Parameter DEPTH_WORDS, 1024, number of WIDTH-bit words in the backing array.
REQ-003 Parameter WAIT_CYCLES, 1, wait states inserted between request accept and response (legal range 0..15).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  core presents a request.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  WIDTH  byte address.
REQ-010 req_wdata  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 req_size  in  2  mem_size_t: BYTE=00, HALF=01, WORD=10 (equals funct3[1:0]).
REQ-012 req_unsigned  in  1  zero-extend loads (equals funct3[2]).
REQ-013 resp_valid  out  1  response available.
REQ-014 resp_ready  in  1  core accepts the response.
REQ-015 resp_rdata  out  WIDTH  load result, extended to WIDTH; 0 for stores and errors.
REQ-016 resp_err  out  1  misaligned or out-of-range access.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESPOND; req_ready = 1 only in IDLE.
REQ-018 The block SHALL accept a request on a rising edge with req_valid && req_ready, capturing we, addr, wdata, size, unsigned.
REQ-019 On accept: if WAIT_CYCLES = 0 the FSM SHALL go to RESPOND; otherwise go to WAIT with the counter loaded with WAIT_CYCLES-1.
REQ-020 In WAIT the counter SHALL decrement each cycle; the FSM SHALL go to RESPOND on the edge where the counter is 0.
REQ-021 resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 A store commit and a load array read SHALL both occur on the edge entering RESPOND, with resp_rdata and resp_err registered on that same edge.
REQ-023 In RESPOND, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_valid && resp_ready, then the FSM SHALL return to IDLE.
REQ-024 Only one request SHALL be outstanding at a time, and req_valid outside IDLE SHALL be ignored (no accept in the response-handshake cycle).
REQ-025 An access SHALL be an error if HALF with addr[0] != 0, WORD with addr[1:0] != 0, addr[WIDTH-1:2] >= DEPTH_WORDS, or req_size = 11.
REQ-026 On error, stores SHALL not modify the array, and resp_rdata SHALL be 0 with resp_err = 1.
REQ-027 SB SHALL write only lane addr[1:0], and SH only lanes {addr[1],0} and {addr[1],1}; other bytes stay unchanged.
REQ-028 A load SHALL extract the addressed byte or half, then sign-extend it (req_unsigned=0) or zero-extend it (req_unsigned=1); req_unsigned SHALL be ignored for WORD.
REQ-029 A store response SHALL return resp_rdata = 0 and resp_err = 0 when legal.
REQ-030 Byte lanes SHALL be little-endian: lane 0 = bits [7:0].

Reset
REQ-031 While rst is asserted the block SHALL hold state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, and req_ready = 1 after release.
REQ-032 Reset SHALL NOT clear the array, and a store captured but not yet committed SHALL be discarded.

Structure
REQ-033 mem_size_t SHALL live in the shared package rv32i_opcodes alongside the opcode types.
REQ-034 Lane logic (store byte-enable/merge and load extract/extend) SHALL be a combinational sub-module mem_lane_align.
REQ-035 The array SHALL be a synchronous-write register array inside mem_responder.

Verification
REQ-036 WAIT_CYCLES=1: SW 0x10 = 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid 2 cycles after each accept.
REQ-037 SB 0x13 wdata 0x000000AA, then LB 0x13 -> 0xFFFFFFAA; LBU 0x13 -> 0x000000AA; LW 0x10 -> 0xAAADBEEF; LH 0x12 -> 0xFFFFAAAD.
REQ-038 LH 0x11 -> err 1, rdata 0; SW 0x12 = 0x0 -> err 1, then LW 0x10 still 0xAAADBEEF; LW DEPTH_WORDS*4 -> err 1.
REQ-039 Hold resp_ready = 0 for 5 cycles with req_valid = 1 -> resp_valid/rdata stable, req_ready 0, no second accept.
REQ-040 rst pulsed in WAIT of SW 0x20 = 0x12345678 (0x20 previously 0x0BADF00D) -> outputs at reset values; then LW 0x20 -> 0x0BADF00D.
REQ-041 Repeat REQ-036 with WAIT_CYCLES=0 -> resp_valid 1 cycle after accept.

Source files
------------

// File: rtl/rv32i_opcodes.sv
// Shared RV32I types: base opcodes, load/store access size and the responder state encoding.
package rv32i_opcodes;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    // Encoding matches funct3[1:0] of loads and stores.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_RESPOND = 2'b10
    } resp_state_t;

    function automatic logic size_addr_illegal(mem_size_t size, logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr_lo[0];
            MEM_WORD: return addr_lo != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between a core (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int WIDTH = 32
);
    import rv32i_opcodes::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    mem_size_t        req_size;
    logic             req_unsigned;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane handling: store merge into the current word and load extract/extend.
module mem_lane_align import rv32i_opcodes::*; #(
    parameter int WIDTH = 32
) (
    input  mem_size_t        size,
    input  logic             is_unsigned,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] word_in,
    output logic [WIDTH-1:0] word_merged,
    output logic [WIDTH-1:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = word_in[{addr_lo, 3'b000} +: 8];
    assign ld_half = word_in[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        word_merged = word_in;
        case (size)
            MEM_BYTE: word_merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            MEM_HALF: word_merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            MEM_WORD: word_merged = wdata;
            default:  word_merged = word_in;
        endcase
    end

    // Extension bit is the sign bit for signed loads and zero otherwise.
    always_comb begin
        load_data = '0;
        case (size)
            MEM_BYTE: load_data = {{(WIDTH-8){ld_byte[7] & ~is_unsigned}}, ld_byte};
            MEM_HALF: load_data = {{(WIDTH-16){ld_half[15] & ~is_unsigned}}, ld_half};
            MEM_WORD: load_data = word_in;
            default:  load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over a register array with programmable wait states.
//   state      | meaning
//   ST_IDLE    | req_ready high, accepting one request
//   ST_WAIT    | request captured, counting down wait states
//   ST_RESPOND | response registered, held until resp_ready
module mem_responder import rv32i_opcodes::*; #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WIDTH-1:0] DEPTH_LIM = WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    resp_state_t      state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic             accept, enter_resp, commit;

    logic             cap_we, cap_unsigned;
    logic [WIDTH-1:0] cap_addr, cap_wdata;
    mem_size_t        cap_size;

    logic             op_we, op_unsigned, op_err;
    logic [WIDTH-1:0] op_addr, op_wdata;
    mem_size_t        op_size;

    logic [WIDTH-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]    word_idx;
    logic [WIDTH-1:0] rd_word, merged_word, load_data;
    logic [WIDTH-1:0] resp_rdata_q;
    logic             resp_err_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESPOND;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_next = ST_RESPOND;
                else             cnt_next   = cnt - 4'd1;
            end
            ST_RESPOND: if (bus.resp_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // With zero wait states the access completes on the accept edge, so the live request is used.
    assign op_we       = (state == ST_IDLE) ? bus.req_we       : cap_we;
    assign op_addr     = (state == ST_IDLE) ? bus.req_addr     : cap_addr;
    assign op_wdata    = (state == ST_IDLE) ? bus.req_wdata    : cap_wdata;
    assign op_size     = (state == ST_IDLE) ? bus.req_size     : cap_size;
    assign op_unsigned = (state == ST_IDLE) ? bus.req_unsigned : cap_unsigned;

    assign op_err     = size_addr_illegal(op_size, op_addr[1:0]) ||
                        ({2'b00, op_addr[WIDTH-1:2]} >= DEPTH_LIM);
    assign enter_resp = (state != ST_RESPOND) && (state_next == ST_RESPOND);
    assign commit     = enter_resp && op_we && !op_err && !rst;
    assign word_idx   = op_addr[AW+1:2];
    assign rd_word    = mem[word_idx];

    mem_lane_align #(.WIDTH(WIDTH)) u_lane (
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .addr_lo     (op_addr[1:0]),
        .wdata       (op_wdata),
        .word_in     (rd_word),
        .word_merged (merged_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (enter_resp) begin
                resp_rdata_q <= (op_we || op_err) ? '0 : load_data;
                resp_err_q   <= op_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we       <= bus.req_we;
            cap_addr     <= bus.req_addr;
            cap_wdata    <= bus.req_wdata;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[word_idx] <= merged_word;
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESPOND);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with one wait state and one with none, checked against a byte-array model.
module tb_mem_responder;
    import rv32i_opcodes::*;

    localparam int DEPTH_TB = 64;
    localparam int NBYTES   = DEPTH_TB * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = 2'b10;
    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [31:0] o_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] bmem [2][NBYTES];

    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(32)) bus0 ();
    mem_responder_if #(.WIDTH(32)) bus1 ();

    assign bus0.req_valid    = ~sel & req_valid;
    assign bus1.req_valid    =  sel & req_valid;
    assign bus0.resp_ready   = ~sel & resp_ready;
    assign bus1.resp_ready   =  sel & resp_ready;
    assign bus0.req_we       = req_we;
    assign bus1.req_we       = req_we;
    assign bus0.req_addr     = req_addr;
    assign bus1.req_addr     = req_addr;
    assign bus0.req_wdata    = req_wdata;
    assign bus1.req_wdata    = req_wdata;
    assign bus0.req_size     = mem_size_t'(req_size);
    assign bus1.req_size     = mem_size_t'(req_size);
    assign bus0.req_unsigned = req_unsigned;
    assign bus1.req_unsigned = req_unsigned;

    assign o_req_ready  = sel ? bus1.req_ready  : bus0.req_ready;
    assign o_resp_valid = sel ? bus1.resp_valid : bus0.resp_valid;
    assign o_resp_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
    assign o_resp_err   = sel ? bus1.resp_err   : bus0.resp_err;

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH_TB), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH_TB), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut wait=%0d)", tag, obs, exp, sel);
        end
    endtask

    // Byte-addressed reference: an access is n = 2^size bytes starting at addr.
    task automatic model(input logic we_i, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns_i,
                         output logic [31:0] rd, output logic e);
        int n;
        logic [63:0] v;
        n  = 1 << sz;
        e  = (sz == 2'd3) || ((a % n) != 0) || ((a / 4) >= DEPTH_TB);
        rd = '0;
        if (!e) begin
            if (we_i) begin
                for (int i = 0; i < n; i++) bmem[sel][a + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (64'(bmem[sel][a + i]) << (8 * i));
                if (!uns_i && n < 4 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input logic we_i, input logic [31:0] addr_i, input logic [31:0] wdata_i,
                       input logic [1:0] size_i, input logic uns_i, input int hold,
                       input logic keep_valid, input logic use_exp,
                       input logic [31:0] exp_rd_i, input logic exp_err_i);
        logic [31:0] m_rd;
        logic        m_err;
        int          lat;
        model(we_i, addr_i, wdata_i, size_i, uns_i, m_rd, m_err);
        if (use_exp) begin
            m_rd  = exp_rd_i;
            m_err = exp_err_i;
        end
        check_eq("req_ready_idle", 32'(o_req_ready), 32'd1);
        req_valid = 1'b1; req_we = we_i; req_addr = addr_i; req_wdata = wdata_i;
        req_size = size_i; req_unsigned = uns_i; resp_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        // Request fields change after accept; the response must come from the captured copy.
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        while (!o_resp_valid && lat < 20) begin
            check_eq("req_ready_wait", 32'(o_req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), sel ? 32'd2 : 32'd1);
        check_eq("rdata", o_resp_rdata, m_rd);
        check_eq("err", 32'(o_resp_err), 32'(m_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(o_resp_valid), 32'd1);
            check_eq("hold_rdata", o_resp_rdata, m_rd);
            check_eq("hold_err", 32'(o_resp_err), 32'(m_err));
            check_eq("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        req_valid  = keep_valid;
        @(negedge clk);
        check_eq("post_valid", 32'(o_resp_valid), 32'd0);
        check_eq("post_req_ready", 32'(o_req_ready), 32'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic random_txns(input int count);
        logic        we_r;
        logic [1:0]  sz_r;
        logic [31:0] a_r;
        int          r;
        for (int k = 0; k < count; k++) begin
            we_r = 1'($urandom);
            r    = $urandom_range(0, 9);
            sz_r = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a_r  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 31));
            txn(we_r, a_r, $urandom, sz_r, 1'($urandom), $urandom_range(0, 3),
                1'($urandom), 1'b0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("rst_resp_valid", 32'(o_resp_valid), 32'd0);
            check_eq("rst_rdata", o_resp_rdata, 32'd0);
            check_eq("rst_err", 32'(o_resp_err), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("rst_release_ready", 32'(o_req_ready), 32'd1);
        end
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < DEPTH_TB; w++)
                txn(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        end

        sel = 1'b1;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h13, 32'h000000AA, 2'd0, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        txn(1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 0, 1'b0, 1'b1, 32'hFFFFFFAA, 1'b0);
        txn(1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 0, 1'b0, 1'b1, 32'h000000AA, 1'b0);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'hAAADBEEF, 1'b0);
        txn(1'b0, 32'h12, 32'h0,        2'd1, 1'b0, 0, 1'b0, 1'b1, 32'hFFFFAAAD, 1'b0);
        txn(1'b0, 32'h11, 32'h0,        2'd1, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        txn(1'b1, 32'h12, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'hAAADBEEF, 1'b0);
        txn(1'b0, 32'(DEPTH_TB * 4), 32'h0, 2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 5, 1'b1, 1'b1, 32'hAAADBEEF, 1'b0);

        // Reset while a store sits in WAIT: the store must be lost and the array untouched.
        txn(1'b1, 32'h20, 32'h0BADF00D, 2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        txn(1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        check_eq("wait_before_rst", 32'(o_req_ready), 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_resp_valid", 32'(o_resp_valid), 32'd0);
        check_eq("midrst_rdata", o_resp_rdata, 32'd0);
        check_eq("midrst_err", 32'(o_resp_err), 32'd0);
        @(negedge clk);
        check_eq("midrst_hold_valid", 32'(o_resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("midrst_release_ready", 32'(o_req_ready), 32'd1);
        @(negedge clk);
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        random_txns(150);

        sel = 1'b0;
        @(negedge clk);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 5, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        random_txns(150);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
